// File: rtl/multi_rate_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : multi_rate_clk_gen
// Description : Multi-channel slow square-wave generator. Each channel
//               produces a 50% duty clock with a programmable half-period
//               and a one-cycle tick on every rising edge. Channels can be
//               enabled individually and re-phased together with realign.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_rate_clk_gen #(
  parameter int                       NUM_CH       = 4,
  parameter int                       CNT_W        = 28,
  parameter logic [NUM_CH*CNT_W-1:0]  DEFAULT_HALF = {28'd12_500_000, 28'd25_000_000,
                                                      28'd50_000_000, 28'd100_000_000},
  localparam int                      WR_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              realign,
  input  logic              wr_en,
  input  logic [WR_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W-1:0] w_term;
    logic             w_wr;

    // Indices at or beyond NUM_CH never match any channel, so such writes drop.
    assign w_wr   = wr_en && (wr_ch == WR_W'(i));
    // A zero half-period is treated as one cycle, so the terminal count is 0.
    assign w_term = (r_half == '0) ? '0 : (r_half - CNT_W'(1));

    // Half-period register, counter, square wave and rising-edge tick.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_half <= DEFAULT_HALF[i*CNT_W +: CNT_W];
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        // The half register loads even when realign or disable owns the counter.
        if (w_wr) begin
          r_half <= wr_half;
        end
        if (realign || !ch_en[i]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_wr) begin
          // Restart the current half-phase with the new length; level is kept.
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else if (r_cnt == w_term) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule
`default_nettype wire
